// File: rtl/qnn_requant_stage_if.sv
// +--------------------------------------------------------------------------+
// | qnn_requant_stage_if : request/result bundle for the requant stage        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface qnn_requant_stage_if #(
   parameter int DIM    = 16,
   parameter int MULT_W = 16,
   parameter int IDX_W  = $clog2(DIM)
);
   logic                  start;
   logic [1:0]            prec;
   logic [MULT_W-1:0]     mult;
   logic [4:0]            shift;
   logic [32*DIM-1:0]     in_vec;
   logic [8*DIM-1:0]      out8;
   logic [4*DIM-1:0]      out4;
   logic [DIM-1:0]        outb;
   logic [IDX_W-1:0]      argmax;
   logic [31:0]           max_val;
   logic                  busy;
   logic                  done;

   modport master (
      output start, prec, mult, shift, in_vec,
      input  out8, out4, outb, argmax, max_val, busy, done
   );

   modport slave (
      input  start, prec, mult, shift, in_vec,
      output out8, out4, outb, argmax, max_val, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/qnn_requant_stage.sv
// +--------------------------------------------------------------------------+
// | qnn_requant_stage : per-element rescale/saturate plus running argmax      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module qnn_requant_stage #(
   parameter int DIM    = 16,
   parameter int MULT_W = 16,
   parameter int IDX_W  = $clog2(DIM)
) (
   input  wire logic              clk,
   input  wire logic              rst,
   qnn_requant_stage_if.slave     bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [1:0]            prec_q;
   logic [MULT_W-1:0]     mult_q;
   logic [4:0]            shift_q;
   logic [31:0]           buf_q [DIM];
   logic [8*DIM-1:0]      out8_q;
   logic [4*DIM-1:0]      out4_q;
   logic [DIM-1:0]        outb_q;
   logic [IDX_W-1:0]      argmax_q;
   logic [31:0]           max_q;
   logic                  busy_q;
   logic                  done_q;

   logic [31:0]           cur_x;
   logic signed [48:0]    x_ext;
   logic signed [48:0]    m_ext;
   logic signed [48:0]    prod;
   logic signed [48:0]    rnd;
   logic signed [48:0]    sum;
   logic signed [48:0]    r;
   logic [7:0]            elem8_d;
   logic [3:0]            elem4_d;
   logic                  elemb_d;

   assign cur_x = buf_q[idx_q];

   // 49 bits hold |x*mult| < 2^47 plus the rounding bias without overflow.
   always_comb begin
      x_ext = {{17{cur_x[31]}}, cur_x};
      m_ext = {{(49-MULT_W){1'b0}}, mult_q};
      prod  = x_ext * m_ext;
      rnd   = (shift_q == 5'd0) ? '0 : (49'sd1 <<< (shift_q - 5'd1));
      sum   = prod + rnd;
      r     = sum >>> shift_q;

      if (r > 49'sd127)       elem8_d = 8'h7F;
      else if (r < -49'sd128) elem8_d = 8'h80;
      else                    elem8_d = r[7:0];

      if (r > 49'sd7)         elem4_d = 4'h7;
      else if (r < -49'sd8)   elem4_d = 4'h8;
      else                    elem4_d = r[3:0];

      elemb_d = (r > 49'sd0);
   end

   // Input snapshot; the caller may change in_vec freely once the run starts.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && bus.start && !rst) begin
         for (int i = 0; i < DIM; i++) begin
            buf_q[i] <= bus.in_vec[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         prec_q   <= '0;
         mult_q   <= '0;
         shift_q  <= '0;
         out8_q   <= '0;
         out4_q   <= '0;
         outb_q   <= '0;
         argmax_q <= '0;
         max_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  prec_q   <= bus.prec;
                  mult_q   <= bus.mult;
                  shift_q  <= bus.shift;
                  out8_q   <= '0;
                  out4_q   <= '0;
                  outb_q   <= '0;
                  argmax_q <= '0;
                  max_q    <= 32'h8000_0000;
                  idx_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SCAN;
               end
            end
            S_SCAN: begin
               case (prec_q)
                  2'd0:    out8_q[8*idx_q +: 8] <= elem8_d;
                  2'd1:    out4_q[4*idx_q +: 4] <= elem4_d;
                  default: outb_q[idx_q]        <= elemb_d;
               endcase
               // Strict compare keeps the earliest index on ties.
               if ($signed(cur_x) > $signed(max_q)) begin
                  max_q    <= cur_x;
                  argmax_q <= idx_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= S_DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.out8    = out8_q;
   assign bus.out4    = out4_q;
   assign bus.outb    = outb_q;
   assign bus.argmax  = argmax_q;
   assign bus.max_val = max_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_qnn_requant_stage.sv
// +--------------------------------------------------------------------------+
// | tb_qnn_requant_stage : directed + random runs against a reference model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_qnn_requant_stage;

   localparam int DIM    = 16;
   localparam int MULT_W = 16;
   localparam int IDX_W  = 4;

   typedef struct {
      logic [8*DIM-1:0] o8;
      logic [4*DIM-1:0] o4;
      logic [DIM-1:0]   ob;
      logic [IDX_W-1:0] am;
      logic [31:0]      mv;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];
   exp_t got_e;

   qnn_requant_stage_if #(.DIM(DIM), .MULT_W(MULT_W), .IDX_W(IDX_W)) bus ();

   qnn_requant_stage #(.DIM(DIM), .MULT_W(MULT_W), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [8*DIM-1:0] act, input logic [8*DIM-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Floor-division formulation of round-half-up, then clamp per format.
   function automatic exp_t model(input logic [32*DIM-1:0] v, input logic [1:0] pr,
                                  input logic [MULT_W-1:0] m, input logic [4:0] s);
      exp_t   e;
      longint x, p, num, d, q, half, c, best;
      e.o8 = '0; e.o4 = '0; e.ob = '0; e.am = '0;
      best = -64'sd2147483648;
      for (int i = 0; i < DIM; i++) begin
         x    = longint'($signed(v[32*i +: 32]));
         p    = x * longint'(m);
         half = (s == 5'd0) ? 64'sd0 : (64'sd1 << (s - 5'd1));
         d    = 64'sd1 << s;
         num  = p + half;
         q    = num / d;
         if ((num % d) != 0 && num < 0) q = q - 1;
         if (pr == 2'd0) begin
            c = (q > 127) ? 127 : ((q < -128) ? -128 : q);
            e.o8[8*i +: 8] = 8'(c);
         end else if (pr == 2'd1) begin
            c = (q > 7) ? 7 : ((q < -8) ? -8 : q);
            e.o4[4*i +: 4] = 4'(c);
         end else begin
            e.ob[i] = (q > 0);
         end
         if (x > best) begin
            best = x;
            e.am = IDX_W'(i);
         end
      end
      e.mv = 32'(best);
      return e;
   endfunction

   function automatic logic [32*DIM-1:0] rand_vec();
      logic [32*DIM-1:0] v;
      for (int i = 0; i < DIM; i++) begin
         case ($urandom_range(0, 3))
            0:       v[32*i +: 32] = $urandom;
            1:       v[32*i +: 32] = 32'($urandom_range(0, 300));
            2:       v[32*i +: 32] = 32'(int'($urandom_range(0, 600)) - 300);
            default: v[32*i +: 32] = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         endcase
      end
      return v;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding run.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending run");
         end else begin
            got_e = sb.pop_front();
            check("out8",    bus.out8,    got_e.o8);
            check("out4",    bus.out4,    got_e.o4);
            check("outb",    bus.outb,    got_e.ob);
            check("argmax",  bus.argmax,  got_e.am);
            check("max_val", bus.max_val, got_e.mv);
            check("busy_at_done", bus.busy, 1'b0);
         end
      end
   end

   task automatic run(input logic [32*DIM-1:0] v, input logic [1:0] pr,
                      input logic [MULT_W-1:0] m, input logic [4:0] s, input bit poke);
      int n;
      bit seen;
      @(negedge clk);
      bus.in_vec = v; bus.prec = pr; bus.mult = m; bus.shift = s; bus.start = 1'b1;
      sb.push_back(model(v, pr, m, s));
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.in_vec = rand_vec();
      bus.prec   = 2'($urandom);
      bus.mult   = MULT_W'($urandom);
      bus.shift  = 5'($urandom);
      check("busy_after_start", bus.busy, 1'b1);
      n = 0; seen = 1'b0;
      while (!seen && n < 4*DIM) begin
         @(posedge clk); n++; #1;
         bus.start = (poke && n == 3);
         if (n == DIM) check("busy_in_done_state", bus.busy, 1'b1);
         if (bus.done) seen = 1'b1;
      end
      bus.start = 1'b0;
      check("latency", 32'(n), 32'(DIM + 1));
   endtask

   initial begin
      logic [32*DIM-1:0] v;
      int n, k, last;
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [32*DIM-1:0] v;
      int n, k, last;
      bus.start = 0; bus.prec = 0; bus.mult = 0; bus.shift = 0; bus.in_vec = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out8", bus.out8, '0);
      check("rst_argmax_maxval", {bus.argmax, bus.max_val}, '0);
      check("rst_busy_done", {bus.busy, bus.done}, 2'b00);
      rst = 1'b0;

      // INT8 saturation and argmax
      for (int i = 0; i < DIM; i++) v[32*i +: 32] = 32'(20 * i);
      run(v, 2'd0, 16'd1, 5'd0, 1'b0);
      check("t1_out8_6",  bus.out8[8*6 +: 8],  8'd120);
      check("t1_out8_7",  bus.out8[8*7 +: 8],  8'd127);
      check("t1_out8_15", bus.out8[8*15 +: 8], 8'd127);
      check("t1_argmax",  bus.argmax, 4'd15);
      check("t1_max_val", bus.max_val, 32'd300);

      // Rounding 3.75 -> 4, 4.5 -> 5, -4.5 -> -4
      v = '0; v[31:0] = 32'd5; v[63:32] = 32'd6; v[95:64] = -32'sd6;
      run(v, 2'd0, 16'd3, 5'd2, 1'b0);
      check("t2_round", bus.out8[23:0], 24'hFC_05_04);

      // INT4 clamping
      v = '0; v[31:0] = -32'sd10; v[63:32] = -32'sd8; v[95:64] = 32'd7; v[127:96] = 32'd9;
      run(v, 2'd1, 16'd1, 5'd0, 1'b1);
      check("t3_out4", bus.out4[15:0], 16'h7788);
      check("t3_out8_zero", bus.out8, '0);

      // Binary
      v = '0; v[63:32] = 32'd1; v[95:64] = -32'sd3;
      run(v, 2'd2, 16'd1, 5'd0, 1'b0);
      check("t4_outb", bus.outb[2:0], 3'b010);
      check("t4_out48_zero", {bus.out8, bus.out4}, '0);

      // Argmax tie keeps lowest index
      v = '0; v[32*3 +: 32] = 32'd500; v[32*9 +: 32] = 32'd500;
      run(v, 2'd0, 16'd1, 5'd0, 1'b1);
      check("t5_argmax", {bus.argmax, bus.max_val}, {4'd3, 32'd500});

      // All minimum values
      for (int i = 0; i < DIM; i++) v[32*i +: 32] = 32'h8000_0000;
      run(v, 2'd3, 16'd7, 5'd1, 1'b0);
      check("t6_argmax", {bus.argmax, bus.max_val}, {4'd0, 32'h8000_0000});

      // start held high: back-to-back runs every DIM+2 cycles
      v = rand_vec();
      @(negedge clk);
      bus.in_vec = v; bus.prec = 2'd0; bus.mult = 16'd77; bus.shift = 5'd4; bus.start = 1'b1;
      repeat (3) sb.push_back(model(v, 2'd0, 16'd77, 5'd4));
      n = 0; k = 0; last = 0;
      while (k < 3 && n < 200) begin
         @(posedge clk); n++; #1;
         if (bus.done) begin
            if (k == 0) check("held_first", 32'(n), 32'(DIM + 2));
            else        check("held_period", 32'(n - last), 32'(DIM + 2));
            last = n; k++;
            if (k == 3) bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("held_runs", 32'(k), 32'd3);

      // Reset during the 6th SCAN cycle, with a competing start
      for (int i = 0; i < DIM; i++) v[32*i +: 32] = 32'(20 * i + 1);
      @(negedge clk);
      bus.in_vec = v; bus.prec = 2'd0; bus.mult = 16'd1; bus.shift = 5'd0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_busy_done", {bus.busy, bus.done}, 2'b00);
      check("mid_rst_out", {bus.out8, bus.out4, bus.outb}, '0);
      check("mid_rst_arg", {bus.argmax, bus.max_val}, '0);
      rst = 1'b0; bus.start = 1'b0;
      repeat (25) @(posedge clk);
      check("mid_rst_idle", bus.busy, 1'b0);
      run(v, 2'd0, 16'd1, 5'd0, 1'b0);

      // Randomized runs
      for (int t = 0; t < 40; t++) begin
         run(rand_vec(), 2'($urandom),
             ($urandom_range(0, 1) != 0) ? MULT_W'($urandom) : MULT_W'($urandom_range(0, 8)),
             5'($urandom_range(0, 31)), $urandom_range(0, 1) != 0);
      end

      repeat (30) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/qnn_requant_stage.md
# qnn_requant_stage

Requantization and argmax stage that sits directly downstream of the dense layer. It consumes the layer's DIM signed 32-bit post-ReLU accumulator outputs and rescales each one with a fixed-point multiplier and shift, using round-half-up. Each result is saturated into the precision the next layer expects: INT8, INT4 or binary. While scanning, it also tracks the argmax and maximum of the raw inputs for classification.

## Interface
Parameters:
- DIM, 16, vector length; must be ≥2.
- MULT_W, 16, width of the unsigned scale multiplier.
- IDX_W, $clog2(DIM), argmax index width.

Ports (clock and reset are decided: one clock, synchronous active-high reset):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a run; sampled only in IDLE.
- prec  in  2  output format: 0=INT8, 1=INT4, 2 or 3=BIN; latched at start.
- mult  in  MULT_W  unsigned scale; latched at start.
- shift  in  5  right shift amount, 0..31; latched at start.
- in_vec  in  32×DIM  signed inputs; captured into an internal buffer at start.
- out8  out  8×DIM  signed INT8 results.
- out4  out  4×DIM  signed INT4 results.
- outb  out  1×DIM  binary results: 1 ⇒ +1, 0 ⇒ −1.
- argmax  out  IDX_W  index of the largest raw input.
- max_val  out  32  signed value of the largest raw input.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- State machine has three states: IDLE → SCAN → DONE → IDLE.
- IDLE, start=1, at the clock edge:
  - Capture in_vec, prec, mult and shift.
  - Clear out8, out4 and outb to 0 and argmax to 0.
  - Set max_val to 32'h8000_0000.
  - Set idx to 0 and move to SCAN.
- SCAN, one element per cycle, x = buf[idx]:
  - p = x × mult, computed as a 49-bit signed product (mult zero-extended).
  - r = (p + (shift≠0 ? 1<<(shift−1) : 0)) >>> shift, an arithmetic shift (round half toward +∞).
  - INT8: out8[idx] = r clamped to [−128, 127].
  - INT4: out4[idx] = r clamped to [−8, 7].
  - BIN: outb[idx] = (r > 0).
  - Only the array selected by prec is written; the other two stay 0.
  - Argmax: if x > max_val (signed, strict), then max_val ← x and argmax ← idx. Ties keep the lowest index.
  - When idx = DIM−1, move to DONE; otherwise idx++.
- DONE: done ← 1 for exactly one cycle, then move to IDLE.
- Outputs hold their values in IDLE until the next start.
- start is ignored in SCAN and DONE, with no queuing.
- Changes to in_vec, prec, mult or shift after the start edge have no effect on the current run.

## Timing
- Reset values: state=IDLE, done=0, busy=0, out8/out4/outb all 0, argmax=0, max_val=0, idx=0.
- A start sampled at edge T0 means:
  - Element i is written at edge T(i+1).
  - DONE is entered at edge T(DIM).
  - done is high during the cycle after edge T(DIM+1).
  - busy is high from after T0 through the DONE cycle.
- Latency from start to done is DIM+1 edges; DIM=16 gives 17.
- If start is held high continuously, it is re-sampled in the IDLE cycle right after DONE. Runs repeat every DIM+2 cycles.
- rst is asserted at any point, including mid-SCAN or during DONE:
  - At the next edge all outputs return to their reset values.
  - No done pulse is produced.
  - A start in the same cycle as rst is ignored.
- If all inputs equal −2^31: argmax=0 and max_val=32'h8000_0000.

## Test plan
- INT8 saturation and argmax: DIM=16, mult=1, shift=0, in_vec[i]=20·i.
  - out8 = 0,20,…,120, then 127 for i≥7.
  - argmax=15, max_val=300; done 17 edges after start.
- Rounding: INT8, mult=3, shift=2, in_vec[0..2]=5, 6, −6.
  - out8[0..2] = 4, 5, −4 (3.75→4, 4.5→5, −4.5→−4).
- INT4 and BIN clamping, mult=1, shift=0:
  - INT4, in_vec[0..3]=−10, −8, 7, 9 → out4 = −8, −8, 7, 7.
  - BIN, in_vec[0..2]=0, 1, −3 → outb = 0, 1, 0.
  - Non-selected arrays read 0 in both runs.
- Argmax ties and minimum value:
  - in_vec[3]=in_vec[9]=500, all others 0 → argmax=3, max_val=500.
  - All inputs −2^31 → argmax=0.
- Handshake:
  - start pulsed during SCAN → no second run, a single done.
  - start held high → done pulses every 18 cycles for DIM=16.
  - in_vec changed mid-run → results reflect the captured values.
- Reset mid-run: rst pulsed at the 6th SCAN cycle.
  - Next edge: busy=0, all outputs 0, no done.
  - A following start runs normally to completion.
